mul_share_arbiter: RTL and testbench

Shares one sequential shift-add multiplier between two requesters. A round-robin arbiter chooses a requester. The block captures that requester's operands and runs the multiplier for a fixed WIDTH steps. It then returns a tagged product on a valid/ready response channel. It sits between the shift-add multiplier datapath and two client blocks that each need unsigned products.

---
 rtl/mul_pkg.sv | 16 +
 rtl/shift_add_core.sv | 47 ++++
 rtl/mul_share_arbiter.sv | 104 ++++++++++
 tb/tb_mul_share_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared constants for the shared shift-add multiplier: FSM encodings, default width and
// requester IDs.
package mul_pkg;

    localparam int unsigned MUL_WIDTH = 32;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/shift_add_core.sv
// Sequential unsigned shift-add multiplier datapath: one partial-product step per enabled
// clock, product of a and b valid in prod after WIDTH steps.
module shift_add_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] prod
);

    logic [2*WIDTH-1:0] prod_q;
    logic [WIDTH-1:0]   mcand_q;
    logic               carry_q;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH+1:0] shifted;

    // Upper half plus carry accumulates mcand when the current multiplier bit is set.
    always_comb begin
        sum = {carry_q, prod_q[2*WIDTH-1:WIDTH]};
        if (prod_q[0]) begin
            sum = sum + {1'b0, mcand_q};
        end
        shifted = {1'b0, sum, prod_q[WIDTH-1:0]} >> 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q  <= '0;
            mcand_q <= '0;
            carry_q <= 1'b0;
        end else if (load) begin
            prod_q  <= {{WIDTH{1'b0}}, a};
            mcand_q <= b;
            carry_q <= 1'b0;
        end else if (step) begin
            carry_q <= shifted[2*WIDTH];
            prod_q  <= shifted[2*WIDTH-1:0];
        end
    end

    assign prod = prod_q;

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one shift-add multiplier between two requesters, returning a
// tagged product on a valid/ready response channel.
module mul_share_arbiter
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic               resp_id,
    output logic [2*WIDTH-1:0] resp_product,
    output logic               busy
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    mul_state_e      state_q;
    logic [CntW-1:0] cnt_q;
    logic            last_grant_q;
    logic            id_q;

    logic            grant_id;
    logic            idle_open;
    logic            handshake;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant_id = REQ0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant_q;
        end else if (req1_valid) begin
            grant_id = REQ1;
        end
    end

    assign idle_open  = (state_q == MUL_IDLE) && !rst;
    assign req0_ready = idle_open && req0_valid && (grant_id == REQ0);
    assign req1_ready = idle_open && req1_valid && (grant_id == REQ1);
    assign handshake  = req0_ready || req1_ready;
    assign sel_a      = (grant_id == REQ1) ? req1_a : req0_a;
    assign sel_b      = (grant_id == REQ1) ? req1_b : req0_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= MUL_IDLE;
            cnt_q        <= '0;
            last_grant_q <= REQ1;
            id_q         <= REQ0;
        end else begin
            unique case (state_q)
                MUL_IDLE: begin
                    if (handshake) begin
                        id_q    <= grant_id;
                        cnt_q   <= '0;
                        state_q <= MUL_RUN;
                    end
                end
                MUL_RUN: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CntLast) begin
                        state_q <= MUL_DONE;
                    end
                end
                MUL_DONE: begin
                    if (resp_ready) begin
                        last_grant_q <= id_q;
                        state_q      <= MUL_IDLE;
                    end
                end
                default: state_q <= MUL_IDLE;
            endcase
        end
    end

    shift_add_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk  (clk),
        .rst  (rst),
        .load (handshake),
        .step (state_q == MUL_RUN),
        .a    (sel_a),
        .b    (sel_b),
        .prod (resp_product)
    );

    assign resp_valid = (state_q == MUL_DONE);
    assign resp_id    = id_q;
    assign busy       = (state_q != MUL_IDLE);

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed self-checking bench for mul_share_arbiter with hand-computed products.
module tb_mul_share_arbiter;

    localparam int unsigned W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic          resp_valid, resp_ready, resp_id, busy;
    logic [2*W-1:0] resp_product;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;

    always #5 clk = ~clk;

    mul_share_arbiter #(
        .WIDTH(W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_id      (resp_id),
        .resp_product (resp_product),
        .busy         (busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges after a request handshake until resp_valid rises (bounded).
    task automatic wait_resp(output int n);
        n = 0;
        while (!resp_valid && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic resp_handshake();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0; resp_ready = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;

        // Reset state, ready suppressed while rst is high
        req0_valid = 1; req0_a = 3; req0_b = 4;
        tick();
        tick();
        check_eq("rst_resp_valid", resp_valid, 0);
        check_eq("rst_resp_id", resp_id, 0);
        check_eq("rst_product", resp_product, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_req0_ready", req0_ready, 0);

        // Single request 3*4
        rst = 0;
        #1;
        check_eq("t1_req0_ready", req0_ready, 1);
        tick();
        req0_valid = 0;
        check_eq("t1_busy", busy, 1);
        wait_resp(lat);
        check_eq("t1_latency", lat, 32);
        check_eq("t1_id", resp_id, 0);
        check_eq("t1_product", resp_product, 12);
        resp_handshake();
        check_eq("t1_valid_drop", resp_valid, 0);
        check_eq("t1_idle", busy, 0);

        // Both valid from reset: req0 first, req1 right after the response handshake
        req0_valid = 1; req0_a = 5; req0_b = 6;
        req1_valid = 1; req1_a = 7; req1_b = 8;
        do_reset();
        #1;
        check_eq("t2_req0_ready", req0_ready, 1);
        check_eq("t2_req1_ready", req1_ready, 0);
        tick();
        req0_valid = 0;
        wait_resp(lat);
        check_eq("t2a_latency", lat, 32);
        check_eq("t2a_id", resp_id, 0);
        check_eq("t2a_product", resp_product, 30);
        check_eq("t2a_req1_wait", req1_ready, 0);
        resp_handshake();
        check_eq("t2_req1_ready", req1_ready, 1);
        tick();
        req1_valid = 0;
        wait_resp(lat);
        check_eq("t2b_id", resp_id, 1);
        check_eq("t2b_product", resp_product, 56);
        resp_handshake();

        // Continuous requests on both: grants alternate 0,1,0,1
        req0_valid = 1; req0_a = 9;  req0_b = 10;
        req1_valid = 1; req1_a = 11; req1_b = 12;
        #1;
        for (int i = 0; i < 4; i++) begin
            check_eq("t3_req0_ready", req0_ready, (i % 2 == 0) ? 1 : 0);
            check_eq("t3_req1_ready", req1_ready, (i % 2 == 1) ? 1 : 0);
            tick();
            wait_resp(lat);
            check_eq("t3_id", resp_id, (i % 2 == 0) ? 0 : 1);
            check_eq("t3_product", resp_product, (i % 2 == 0) ? 90 : 132);
            resp_handshake();
        end
        req0_valid = 0; req1_valid = 0;

        // Backpressure in DONE with max operands; waiting req1 gets no ready
        req0_valid = 1; req0_a = 32'hFFFF_FFFF; req0_b = 32'hFFFF_FFFF;
        #1;
        tick();
        req0_valid = 0;
        req1_valid = 1; req1_a = 2; req1_b = 3;
        wait_resp(lat);
        check_eq("t4_latency", lat, 32);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("t4_hold_valid", resp_valid, 1);
            check_eq("t4_hold_product", resp_product, 64'hFFFF_FFFE_0000_0001);
            check_eq("t4_hold_id", resp_id, 0);
            check_eq("t4_req1_blocked", req1_ready, 0);
        end
        resp_handshake();
        check_eq("t4_req1_ready", req1_ready, 1);
        tick();
        req1_valid = 0;
        wait_resp(lat);
        check_eq("t4b_id", resp_id, 1);
        check_eq("t4b_product", resp_product, 6);
        resp_handshake();

        // Reset during RUN aborts the operation
        req0_valid = 1; req0_a = 9; req0_b = 9;
        #1;
        tick();
        req0_valid = 0;
        for (int i = 0; i < 10; i++) tick();
        check_eq("t5_busy_run", busy, 1);
        rst = 1;
        tick();
        rst = 0;
        check_eq("t5_busy", busy, 0);
        check_eq("t5_resp_valid", resp_valid, 0);
        check_eq("t5_product_clr", resp_product, 0);
        req0_valid = 1; req0_a = 3; req0_b = 4;
        #1;
        check_eq("t5_req0_ready", req0_ready, 1);
        tick();
        req0_valid = 0;
        wait_resp(lat);
        check_eq("t5_latency", lat, 32);
        check_eq("t5_product", resp_product, 12);
        resp_handshake();

        // Zero multiplier keeps the fixed latency
        req0_valid = 1; req0_a = 0; req0_b = 32'hFFFF_FFFF;
        #1;
        tick();
        req0_valid = 0;
        wait_resp(lat);
        check_eq("t6_latency", lat, 32);
        check_eq("t6_product", resp_product, 0);
        resp_handshake();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
